// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the OTTER icache/dcache main-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT_I = 2'b01,
      GRANT_D = 2'b10
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned BE_W   = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache (i) and dcache (d): single grant
// held until mem_resp or timeout, round-robin on ties, sticky error flags.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BURST_LEN = 32,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_mem_read,
   input  logic                 i_mem_write,
   input  logic [ADDR_W-1:0]    i_mem_address,
   input  logic [BURST_LEN-1:0] i_mem_wdata,
   input  logic [BE_W-1:0]      i_mem_byte_enable,
   output logic                 i_mem_resp,
   output logic [BURST_LEN-1:0] i_mem_rdata,
   input  logic                 d_mem_read,
   input  logic                 d_mem_write,
   input  logic [ADDR_W-1:0]    d_mem_address,
   input  logic [BURST_LEN-1:0] d_mem_wdata,
   input  logic [BE_W-1:0]      d_mem_byte_enable,
   output logic                 d_mem_resp,
   output logic [BURST_LEN-1:0] d_mem_rdata,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [ADDR_W-1:0]    mem_address,
   output logic [BURST_LEN-1:0] mem_wdata,
   output logic [BE_W-1:0]      mem_byte_enable,
   input  logic                 mem_resp,
   input  logic [BURST_LEN-1:0] mem_rdata,
   output logic                 err_timeout,
   output logic                 err_stray_resp
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   arb_state_t    state_q, state_d;
   port_t         last_q, last_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          err_to_q, err_to_d;
   logic          err_stray_q, err_stray_d;

   logic req_i, req_d;
   port_t pick;

   assign req_i = i_mem_read | i_mem_write;
   assign req_d = d_mem_read | d_mem_write;

   // On a tie the port that did not win last time is granted.
   function automatic port_t rr_pick(input logic ri, input logic rd, input port_t last);
      if (ri && rd) return (last == PORT_I) ? PORT_D : PORT_I;
      else if (ri)  return PORT_I;
      else          return PORT_D;
   endfunction

   assign pick = rr_pick(req_i, req_d, last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= PORT_D;
         timer_q     <= '0;
         err_to_q    <= 1'b0;
         err_stray_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         timer_q     <= timer_d;
         err_to_q    <= err_to_d;
         err_stray_q <= err_stray_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      last_d          = last_q;
      timer_d         = timer_q;
      err_to_d        = err_to_q;
      err_stray_d     = err_stray_q;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      i_mem_resp      = 1'b0;
      i_mem_rdata     = '0;
      d_mem_resp      = 1'b0;
      d_mem_rdata     = '0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (mem_resp) err_stray_d = 1'b1;
            if (req_i || req_d) begin
               state_d = (pick == PORT_I) ? GRANT_I : GRANT_D;
               last_d  = pick;
            end
         end
         GRANT_I: begin
            mem_read        = i_mem_read;
            mem_write       = i_mem_write;
            mem_address     = i_mem_address;
            mem_wdata       = i_mem_wdata;
            mem_byte_enable = i_mem_byte_enable;
            i_mem_rdata     = mem_rdata;
            if (mem_resp) begin
               i_mem_resp = 1'b1;
               state_d    = IDLE;
               timer_d    = '0;
            end else if (timer_q == TMAX) begin
               err_to_d = 1'b1;
               state_d  = IDLE;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         GRANT_D: begin
            mem_read        = d_mem_read;
            mem_write       = d_mem_write;
            mem_address     = d_mem_address;
            mem_wdata       = d_mem_wdata;
            mem_byte_enable = d_mem_byte_enable;
            d_mem_rdata     = mem_rdata;
            if (mem_resp) begin
               d_mem_resp = 1'b1;
               state_d    = IDLE;
               timer_d    = '0;
            end else if (timer_q == TMAX) begin
               err_to_d = 1'b1;
               state_d  = IDLE;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign err_timeout    = err_to_q;
   assign err_stray_resp = err_stray_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1ns after posedge, outputs checked 1ns later.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_mem_read, i_mem_write, d_mem_read, d_mem_write;
   logic [31:0] i_mem_address, i_mem_wdata, d_mem_address, d_mem_wdata;
   logic [3:0]  i_mem_byte_enable, d_mem_byte_enable;
   logic        i_mem_resp, d_mem_resp;
   logic [31:0] i_mem_rdata, d_mem_rdata;
   logic        mem_read, mem_write, mem_resp;
   logic [31:0] mem_address, mem_wdata, mem_rdata;
   logic [3:0]  mem_byte_enable;
   logic        err_timeout, err_stray_resp;

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.BURST_LEN(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_mem_address(i_mem_address), .i_mem_wdata(i_mem_wdata),
      .i_mem_byte_enable(i_mem_byte_enable),
      .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
      .d_mem_byte_enable(d_mem_byte_enable),
      .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_byte_enable(mem_byte_enable),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .err_timeout(err_timeout), .err_stray_resp(err_stray_resp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_resp} = '0;
      {i_mem_address, i_mem_wdata, d_mem_address, d_mem_wdata, mem_rdata} = '0;
      i_mem_byte_enable = '0;
      d_mem_byte_enable = '0;
      cyc();
      chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
      chk("rst_err_to", {31'b0, err_timeout}, 32'd0);
      chk("rst_err_stray", {31'b0, err_stray_resp}, 32'd0);
      chk("rst_i_resp", {31'b0, i_mem_resp}, 32'd0);
      rst = 1'b0;

      // Lone icache read
      cyc(); i_mem_read = 1'b1; i_mem_address = 32'h100; #1;
      chk("lone_c0_read", {31'b0, mem_read}, 32'd0);
      cyc(); #1;
      chk("lone_c1_read", {31'b0, mem_read}, 32'd1);
      chk("lone_c1_addr", mem_address, 32'h100);
      cyc(); cyc(); #1;
      chk("lone_c3_iresp", {31'b0, i_mem_resp}, 32'd0);
      cyc(); mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
      chk("lone_c4_iresp", {31'b0, i_mem_resp}, 32'd1);
      chk("lone_c4_irdata", i_mem_rdata, 32'hDEADBEEF);
      chk("lone_c4_dresp", {31'b0, d_mem_resp}, 32'd0);
      chk("lone_c4_drdata", d_mem_rdata, 32'd0);
      cyc(); mem_resp = 1'b0; mem_rdata = '0; i_mem_read = 1'b0; #1;
      chk("lone_c5_idle", {31'b0, mem_read}, 32'd0);

      // Tie after reset: i first, then d, then i again
      do_reset();
      i_mem_read = 1'b1; i_mem_address = 32'h200;
      d_mem_write = 1'b1; d_mem_address = 32'h300;
      d_mem_wdata = 32'h12345678; d_mem_byte_enable = 4'hF; #1;
      chk("tie_arb_cycle", {31'b0, mem_read | mem_write}, 32'd0);
      cyc(); #1;
      chk("tie_i_read", {31'b0, mem_read}, 32'd1);
      chk("tie_i_write", {31'b0, mem_write}, 32'd0);
      chk("tie_i_addr", mem_address, 32'h200);
      cyc(); mem_resp = 1'b1; mem_rdata = 32'hAAAA5555; #1;
      chk("tie_i_resp", {31'b0, i_mem_resp}, 32'd1);
      chk("tie_d_noresp", {31'b0, d_mem_resp}, 32'd0);
      cyc(); mem_resp = 1'b0; i_mem_read = 1'b0; #1;
      chk("tie_gap", {31'b0, mem_write}, 32'd0);
      cyc(); #1;
      chk("tie_d_write", {31'b0, mem_write}, 32'd1);
      chk("tie_d_read", {31'b0, mem_read}, 32'd0);
      chk("tie_d_addr", mem_address, 32'h300);
      chk("tie_d_wdata", mem_wdata, 32'h12345678);
      chk("tie_d_be", {28'b0, mem_byte_enable}, 32'hF);
      cyc(); mem_resp = 1'b1; #1;
      chk("tie_d_resp", {31'b0, d_mem_resp}, 32'd1);
      chk("tie_i_noresp", {31'b0, i_mem_resp}, 32'd0);
      cyc(); mem_resp = 1'b0; d_mem_write = 1'b0;
      cyc(); i_mem_read = 1'b1; i_mem_address = 32'h204;
      d_mem_write = 1'b1; d_mem_address = 32'h304;
      cyc(); #1;
      chk("tie2_i_wins", mem_address, 32'h204);
      chk("tie2_i_read", {31'b0, mem_read}, 32'd1);
      cyc(); mem_resp = 1'b1;
      cyc(); mem_resp = 1'b0; i_mem_read = 1'b0;
      cyc(); mem_resp = 1'b1; #1;
      chk("tie2_d_addr", mem_address, 32'h304);
      chk("tie2_d_resp", {31'b0, d_mem_resp}, 32'd1);
      cyc(); mem_resp = 1'b0; d_mem_write = 1'b0;

      // Late d request during GRANT_I
      cyc(); i_mem_read = 1'b1; i_mem_address = 32'h400;
      cyc();
      cyc(); d_mem_read = 1'b1; d_mem_address = 32'h500; #1;
      chk("late_d_stall", {31'b0, d_mem_resp}, 32'd0);
      chk("late_addr_i", mem_address, 32'h400);
      cyc(); #1;
      chk("late_addr_hold", mem_address, 32'h400);
      cyc(); mem_resp = 1'b1; mem_rdata = 32'h11112222; #1;
      chk("late_i_resp", {31'b0, i_mem_resp}, 32'd1);
      chk("late_d_noresp", {31'b0, d_mem_resp}, 32'd0);
      cyc(); mem_resp = 1'b0; i_mem_read = 1'b0; #1;
      chk("late_r1_idle", {31'b0, mem_read}, 32'd0);
      cyc(); mem_resp = 1'b1; mem_rdata = 32'h33334444; #1;
      chk("late_r2_addr", mem_address, 32'h500);
      chk("late_r2_drdata", d_mem_rdata, 32'h33334444);
      chk("late_r2_irdata", i_mem_rdata, 32'd0);
      cyc(); mem_resp = 1'b0; d_mem_read = 1'b0; mem_rdata = '0;

      // Timeout with TIMEOUT = 8
      cyc(); d_mem_read = 1'b1; d_mem_address = 32'h600;
      cyc(); #1;
      chk("to_g1_addr", mem_address, 32'h600);
      for (int k = 2; k <= 8; k++) cyc();
      #1;
      chk("to_g8_flag", {31'b0, err_timeout}, 32'd0);
      chk("to_g8_read", {31'b0, mem_read}, 32'd1);
      cyc(); #1;
      chk("to_flag_set", {31'b0, err_timeout}, 32'd1);
      chk("to_idle", {31'b0, mem_read}, 32'd0);
      chk("to_no_dresp", {31'b0, d_mem_resp}, 32'd0);
      cyc(); mem_resp = 1'b1; #1;
      chk("to_regrant", mem_address, 32'h600);
      chk("to_regrant_resp", {31'b0, d_mem_resp}, 32'd1);
      chk("to_flag_sticky", {31'b0, err_timeout}, 32'd1);
      cyc(); mem_resp = 1'b0; d_mem_read = 1'b0;

      // Asynchronous reset during GRANT_I
      cyc(); i_mem_read = 1'b1; i_mem_address = 32'h700;
      cyc(); #1;
      chk("rm_granted", {31'b0, mem_read}, 32'd1);
      rst = 1'b1; #1;
      chk("rm_async_read", {31'b0, mem_read}, 32'd0);
      chk("rm_err_to_clr", {31'b0, err_timeout}, 32'd0);
      i_mem_read = 1'b0;
      cyc(); rst = 1'b0;
      cyc(); mem_resp = 1'b1; #1;
      chk("rm_no_iresp", {31'b0, i_mem_resp}, 32'd0);
      chk("rm_no_dresp", {31'b0, d_mem_resp}, 32'd0);
      cyc(); mem_resp = 1'b0; #1;
      chk("rm_stray", {31'b0, err_stray_resp}, 32'd1);

      // Plain stray response in IDLE
      cyc(); do_reset(); #1;
      chk("stray_clr", {31'b0, err_stray_resp}, 32'd0);
      cyc(); mem_resp = 1'b1; mem_rdata = 32'hFFFF0000; #1;
      chk("stray_no_iresp", {31'b0, i_mem_resp}, 32'd0);
      chk("stray_no_dresp", {31'b0, d_mem_resp}, 32'd0);
      chk("stray_irdata", i_mem_rdata, 32'd0);
      cyc(); mem_resp = 1'b0; mem_rdata = '0; #1;
      chk("stray_flag", {31'b0, err_stray_resp}, 32'd1);
      chk("stray_to_clr", {31'b0, err_timeout}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares one main-memory device port between the L1 instruction cache (port i) and the L1 data cache (port d) of the multicycle OTTER.
- Sits between the caches' memory-side controller ports and the main memory device port.
- Grants one requester at a time, holds the grant until mem_resp, and uses round-robin on ties.
- Flags response timeouts and stray responses.

Parameters:
- BURST_LEN, 32, width of read and write data for one memory transaction.
- TIMEOUT, 1024, number of granted cycles without mem_resp before a timeout is declared; must be at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_mem_read  in  1  icache read request; held until i_mem_resp
- i_mem_write  in  1  icache write request; held until i_mem_resp
- i_mem_address  in  32  icache address
- i_mem_wdata  in  BURST_LEN  icache write data
- i_mem_byte_enable  in  4  icache byte enables
- i_mem_resp  out  1  one-cycle completion pulse to icache
- i_mem_rdata  out  BURST_LEN  read data to icache
- d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable, d_mem_resp, d_mem_rdata  same directions, widths and meanings for the dcache
- mem_read  out  1  read request to memory
- mem_write  out  1  write request to memory
- mem_address  out  32  address to memory
- mem_wdata  out  BURST_LEN  write data to memory
- mem_byte_enable  out  4  byte enables to memory
- mem_resp  in  1  memory completion pulse
- mem_rdata  in  BURST_LEN  memory read data
- err_timeout  out  1  sticky: a granted transaction exceeded TIMEOUT
- err_stray_resp  out  1  sticky: mem_resp arrived while IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, last_grant = D, timer = 0.
  - All mem_* outputs, i_/d_mem_resp, i_/d_mem_rdata and both error flags = 0.
- Request definitions: req_x = x_mem_read | x_mem_write. Requesters hold request signals stable until they see their resp pulse, and drop them the following cycle.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Only req_i: go to GRANT_I.
  - Only req_d: go to GRANT_D.
  - Both: grant the port that is not last_grant.
  - Neither: stay in IDLE.
  - On entering a GRANT state, last_grant is updated to that port.
- Latency: a request first seen in cycle C produces mem_read/mem_write in cycle C+1. Arbitration costs exactly one cycle.
- GRANT_x:
  - mem_read, mem_write, mem_address, mem_wdata and mem_byte_enable are combinationally muxed from port x.
  - The other port sees all-zero outputs and its resp stays 0.
- Completion, when mem_resp = 1 in GRANT_x:
  - x_mem_resp = 1 in the same cycle (combinational pass-through).
  - x_mem_rdata = mem_rdata.
  - Next state is IDLE; timer is cleared.
- Back-to-back: no request is sampled in the mem_resp cycle. The earliest next grant is the cycle after IDLE evaluates, so there is a minimum one idle cycle between transactions.
- Ungranted port: x_mem_rdata = 0 and x_mem_resp = 0 at all times.
- Timer:
  - Increments each cycle in a GRANT state without mem_resp.
  - When timer reaches TIMEOUT-1 with no mem_resp: set err_timeout, drive x_mem_resp = 0, return to IDLE; last_grant keeps x.
  - The abandoned requester stays pending and is re-arbitrated.
- Stray response: mem_resp = 1 in IDLE sets err_stray_resp. The response is not forwarded.
- Illegal request: read and write both high on the granted port are forwarded unchanged; memory semantics govern.
- Requester drops its request mid-grant (protocol violation): the grant is held until mem_resp or timeout.
- Error flags: cleared only by rst.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. Any in-flight memory response after reset is treated as stray.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t
  - typedef enum logic {PORT_I, PORT_D} port_t
  - localparam ADDR_W = 32, BE_W = 4
- No sub-module: FSM, timer and output mux fit in a single module.
- The round-robin pick stays an inline function.

Test Plan:
- Lone icache read:
  - Stimulus: i_mem_read = 1, address 0x0000_0100 at cycle 0; memory returns mem_resp with rdata 0xDEADBEEF at cycle 4.
  - Required: mem_read = 1 and mem_address = 0x100 from cycle 1; i_mem_resp = 1 and i_mem_rdata = 0xDEADBEEF at cycle 4; d_mem_resp stays 0.
- Tie after reset, alternation:
  - Stimulus: i read 0x200 and d write 0x300 (wdata 0x12345678, byte_enable 0xF) asserted together.
  - Required: icache granted first; dcache granted on the next IDLE, with mem_wdata = 0x12345678 and mem_byte_enable = 0xF; on a repeated tie, icache wins again.
- Late request during a grant:
  - Stimulus: d request arrives while GRANT_I is waiting.
  - Required: d stalls with d_mem_resp = 0 and mem_address stays the i address; d is granted 2 cycles after i's resp.
- Timeout:
  - Stimulus: TIMEOUT = 8, grant d, memory never responds.
  - Required: err_timeout = 1 after 8 granted cycles; FSM returns to IDLE; d is re-granted; err_timeout stays 1.
- Reset mid-transaction:
  - Stimulus: rst pulsed during GRANT_I.
  - Required: mem_read = 0 immediately (asynchronous); a mem_resp arriving afterwards sets err_stray_resp, and i_mem_resp stays 0.
- Stray response:
  - Stimulus: mem_resp = 1 while IDLE.
  - Required: err_stray_resp = 1; no resp pulse on either port.
